tft_timing_gen: RTL and testbench

Video timing generator and pixel pacer that sits directly upstream of the post-processing stage. It produces the pixel, data-enable, hsync and vsync stream consumed by the TFT output path. It pops RGB565 pixels from a show-ahead frame-buffer FIFO exactly when the active region needs them, and substitutes black on underflow. Every frame is complete: it always starts at raster (0,0) and always runs to the end of the last blanking line.

---
 rtl/tft_timing_gen_pkg.sv | 29 ++
 rtl/tft_raster_counter.sv | 62 ++++++
 rtl/tft_timing_gen.sv | 108 ++++++++++
 tb/tb_tft_timing_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_timing_gen_pkg.sv
// rtl/tft_timing_gen_pkg.sv - shared timing defaults, FSM encoding and pixel constants for the TFT timing generator
package tft_timing_gen_pkg;

    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 2;
    localparam int DEF_H_SYNC   = 41;
    localparam int DEF_H_BP     = 2;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_V_SYNC   = 10;
    localparam int DEF_V_BP     = 2;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tftState;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    // One spare code so a window end equal to the total still fits the counter width.
    function automatic int cntWidth(input int total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/tft_raster_counter.sv
// rtl/tft_raster_counter.sv - hCnt/vCnt raster pair with region, sync-window and frame-boundary flags
module tft_raster_counter
    import tft_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iClear,
    input  logic iAdvance,
    output logic oActive,
    output logic oHsyncWin,
    output logic oVsyncWin,
    output logic oFrameEnd,
    output logic oFrameOrigin
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = cntWidth(H_TOTAL);
    localparam int VW = cntWidth(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hCnt;
    logic [VW-1:0] vCnt;

    always_ff @(posedge iClk) begin
        if (iRst || iClear) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (iAdvance) begin
            if (hCnt == H_LAST) begin
                hCnt <= '0;
                vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
            end else begin
                hCnt <= hCnt + 1'b1;
            end
        end
    end

    assign oActive      = (hCnt < H_ACT_END) && (vCnt < V_ACT_END);
    assign oHsyncWin    = (hCnt >= H_SYNC_START) && (hCnt < H_SYNC_END);
    assign oVsyncWin    = (vCnt >= V_SYNC_START) && (vCnt < V_SYNC_END);
    assign oFrameEnd    = (hCnt == H_LAST) && (vCnt == V_LAST);
    assign oFrameOrigin = (hCnt == '0) && (vCnt == '0);

endmodule

// File: rtl/tft_timing_gen.sv
// rtl/tft_timing_gen.sv - TFT video timing generator and frame-buffer pixel pacer
module tft_timing_gen
    import tft_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        iPixelClk,
    input  logic        iSysRst,
    input  logic        iEnable,
    input  logic [15:0] iPixelData,
    input  logic        iPixelValid,
    output logic        oPixelReady,
    output logic [15:0] oPixel,
    output logic        oVde,
    output logic        oHsync,
    output logic        oVsync,
    output logic        oFrameStart,
    output logic        oUnderflow,
    output logic [15:0] oUnderflowCnt
);

    localparam logic SYNC_OFF = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic SYNC_ON  = ~SYNC_OFF;

    tftState     state;
    tftState     nextState;
    logic        running;
    logic        active;
    logic        hsyncWin;
    logic        vsyncWin;
    logic        frameEnd;
    logic        frameOrigin;
    logic        starve;
    logic [15:0] underflowCnt;

    tft_raster_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) uRaster (
        .iClk         (iPixelClk),
        .iRst         (iSysRst),
        .iClear       (~running),
        .iAdvance     (running),
        .oActive      (active),
        .oHsyncWin    (hsyncWin),
        .oVsyncWin    (vsyncWin),
        .oFrameEnd    (frameEnd),
        .oFrameOrigin (frameOrigin)
    );

    always_ff @(posedge iPixelClk) begin
        if (iSysRst) state <= IDLE;
        else         state <= nextState;
    end

    // RUN and DRAIN share the end-of-frame decision; only there may the raster stop.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:       if (iEnable) nextState = RUN;
            RUN, DRAIN: begin
                if (frameEnd && !iEnable) nextState = IDLE;
                else if (iEnable)         nextState = RUN;
                else                      nextState = DRAIN;
            end
            default:    nextState = IDLE;
        endcase
    end

    assign running     = (state != IDLE);
    assign oPixelReady = running && active;
    assign starve      = running && active && !iPixelValid;

    always_ff @(posedge iPixelClk) begin
        if (iSysRst || !running) begin
            oPixel      <= RGB565_BLACK;
            oVde        <= 1'b0;
            oHsync      <= SYNC_OFF;
            oVsync      <= SYNC_OFF;
            oFrameStart <= 1'b0;
            oUnderflow  <= 1'b0;
        end else begin
            oPixel      <= (active && iPixelValid) ? iPixelData : RGB565_BLACK;
            oVde        <= active;
            oHsync      <= hsyncWin ? SYNC_ON : SYNC_OFF;
            oVsync      <= vsyncWin ? SYNC_ON : SYNC_OFF;
            oFrameStart <= frameOrigin;
            oUnderflow  <= starve;
        end
    end

    // Starvation count survives IDLE so software can read it after a stop.
    always_ff @(posedge iPixelClk) begin
        if (iSysRst)                              underflowCnt <= 16'h0000;
        else if (starve && underflowCnt != 16'hFFFF) underflowCnt <= underflowCnt + 16'h0001;
    end

    assign oUnderflowCnt = underflowCnt;

endmodule

// File: tb/tb_tft_timing_gen.sv
// tb/tb_tft_timing_gen.sv - directed self-checking bench for tft_timing_gen with an 12x7 raster
module tb_tft_timing_gen;

    logic        clk = 1'b0;
    logic        iSysRst;
    logic        iEnable;
    logic [15:0] iPixelData;
    logic        iPixelValid;
    logic        oPixelReady;
    logic [15:0] oPixel;
    logic        oVde;
    logic        oHsync;
    logic        oVsync;
    logic        oFrameStart;
    logic        oUnderflow;
    logic [15:0] oUnderflowCnt;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int fsCyc = -1000;
    int fsPeriod = 0;
    int popTotal = 0;
    int nextShow = 0;
    int pixErr = 0;
    logic lastPop = 1'b0;
    int popCnt, vdeCnt, hsLow, vsLow, ufCnt, ufZeroVde, hsFirst, vsFirst;

    tft_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .iPixelClk     (clk),
        .iSysRst       (iSysRst),
        .iEnable       (iEnable),
        .iPixelData    (iPixelData),
        .iPixelValid   (iPixelValid),
        .oPixelReady   (oPixelReady),
        .oPixel        (oPixel),
        .oVde          (oVde),
        .oHsync        (oHsync),
        .oVsync        (oVsync),
        .oFrameStart   (oFrameStart),
        .oUnderflow    (oUnderflow),
        .oUnderflowCnt (oUnderflowCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIFO model: head holds the index of the next pixel to be popped.
    task automatic step();
        logic pop;
        logic rstSeen;
        pop     = oPixelReady & iPixelValid & ~iSysRst;
        rstSeen = iSysRst;
        @(posedge clk);
        #1;
        cyc++;
        if (rstSeen) begin
            popTotal = 0;
            nextShow = 0;
        end else if (pop) begin
            popTotal++;
        end
        iPixelData = popTotal[15:0];
        lastPop = pop;
        popCnt += int'(pop);
        if (oVde) vdeCnt++;
        if (!oHsync) begin
            hsLow++;
            if (hsFirst < 0) hsFirst = cyc - fsCyc;
        end
        if (!oVsync) begin
            vsLow++;
            if (vsFirst < 0) vsFirst = cyc - fsCyc;
        end
        if (oUnderflow) ufCnt++;
        if (oUnderflow && oVde && oPixel == 16'h0000) ufZeroVde++;
        if (oVde && !oUnderflow) begin
            if (oPixel !== nextShow[15:0]) pixErr++;
            nextShow++;
        end else if (oPixel !== 16'h0000) begin
            pixErr++;
        end
        if (oFrameStart) begin
            fsPeriod = cyc - fsCyc;
            fsCyc = cyc;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Restart per-frame tallies with only the current cycle's contribution.
    task automatic clearStats();
        popCnt    = int'(lastPop);
        vdeCnt    = int'(oVde);
        hsLow     = int'(!oHsync);
        vsLow     = int'(!oVsync);
        ufCnt     = int'(oUnderflow);
        ufZeroVde = 0;
        hsFirst   = -1;
        vsFirst   = -1;
    endtask

    initial begin
        iSysRst = 1'b1;
        iEnable = 1'b1;
        iPixelValid = 1'b1;
        iPixelData = 16'h0000;
        clearStats();
        steps(3);
        check("rst_pixel", oPixel, 16'h0000);
        check("rst_vde", oVde, 1'b0);
        check("rst_hsync", oHsync, 1'b1);
        check("rst_vsync", oVsync, 1'b1);
        check("rst_fs", oFrameStart, 1'b0);
        check("rst_uf", oUnderflow, 1'b0);
        check("rst_ufcnt", oUnderflowCnt, 16'h0000);
        check("rst_ready", oPixelReady, 1'b0);

        // Frame 1: continuous valid data
        iSysRst = 1'b0;
        step();
        check("first_ready", oPixelReady, 1'b1);
        check("first_vde_lag", oVde, 1'b0);
        check("first_fs_early", oFrameStart, 1'b0);
        step();
        check("first_fs", oFrameStart, 1'b1);
        check("first_vde", oVde, 1'b1);
        clearStats();
        steps(83);
        check("f1_pops", popCnt, 32);
        check("f1_vde", vdeCnt, 32);
        check("f1_hs_low", hsLow, 14);
        check("f1_vs_low", vsLow, 12);
        check("f1_hs_pos", hsFirst, 9);
        check("f1_vs_pos", vsFirst, 60);
        step();
        check("f2_fs", oFrameStart, 1'b1);
        check("f2_period", fsPeriod, 84);

        // Frame 2: three starved pixels at hCnt 3..5 of line 0
        clearStats();
        steps(2);
        iPixelValid = 1'b0;
        steps(3);
        iPixelValid = 1'b1;
        steps(78);
        check("uf_pulses", ufCnt, 3);
        check("uf_zero_vde", ufZeroVde, 3);
        check("uf_cnt", oUnderflowCnt, 16'h0003);
        check("uf_pops", popCnt, 29);
        check("uf_vde", vdeCnt, 32);
        step();
        check("uf_next_fs", oFrameStart, 1'b1);
        check("uf_period", fsPeriod, 84);

        // Frame 3: enable dropped at (3,1) and restored during drain
        clearStats();
        steps(14);
        iEnable = 1'b0;
        steps(10);
        iEnable = 1'b1;
        steps(59);
        check("drain_pops", popCnt, 32);
        step();
        check("drain_fs", oFrameStart, 1'b1);
        check("drain_period", fsPeriod, 84);

        // Frame 4: enable dropped at (3,1) and left low
        clearStats();
        steps(14);
        iEnable = 1'b0;
        steps(69);
        check("stop_pops", popCnt, 32);
        check("stop_vde", vdeCnt, 32);
        step();
        check("stop_no_fs", oFrameStart, 1'b0);
        check("stop_ready", oPixelReady, 1'b0);
        clearStats();
        steps(100);
        check("idle_pops", popCnt, 0);
        check("idle_vde", vdeCnt, 0);
        check("idle_hs", hsLow, 0);
        check("idle_vs", vsLow, 0);

        // Reset mid-active-line
        iEnable = 1'b1;
        steps(2);
        check("restart_fs", oFrameStart, 1'b1);
        steps(4);
        check("pre_rst_vde", oVde, 1'b1);
        iSysRst = 1'b1;
        iEnable = 1'b0;
        step();
        check("mid_rst_vde", oVde, 1'b0);
        check("mid_rst_pixel", oPixel, 16'h0000);
        check("mid_rst_hsync", oHsync, 1'b1);
        check("mid_rst_vsync", oVsync, 1'b1);
        check("mid_rst_ufcnt", oUnderflowCnt, 16'h0000);
        check("mid_rst_ready", oPixelReady, 1'b0);
        iSysRst = 1'b0;
        steps(2);
        iEnable = 1'b1;
        step();
        check("post_rst_fs_early", oFrameStart, 1'b0);
        step();
        check("post_rst_fs", oFrameStart, 1'b1);

        // Saturation of the starvation counter
        clearStats();
        force dut.underflowCnt = 16'hFFFE;
        step();
        release dut.underflowCnt;
        step();
        check("sat_preset", oUnderflowCnt, 16'hFFFE);
        iPixelValid = 1'b0;
        steps(3);
        iPixelValid = 1'b1;
        check("sat_pulses", ufCnt, 3);
        check("sat_cnt", oUnderflowCnt, 16'hFFFF);
        step();
        check("sat_hold", oUnderflowCnt, 16'hFFFF);

        check("pixel_seq", pixErr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
